// File: rtl/conv_stream_ctrl.sv
// conv_stream_ctrl: streams a W x H image from the input RAM in raster
// order and drives shift/zero-select to a KxK line-buffer datapath.
// It flags strided windows with output coordinates behind a ready/valid handshake.
// Ports: clk, rst (async active-low), start, stride, out_ready ->
//        rd_inram, pixadr, init0, sh, sel0, avail, out_row, out_col,
//        busy, done.
// Optional: define CONV_STALL_CNT_EN to add stall_cnt[15:0], a saturating
// count of stalled cycles in the current frame.
module conv_stream_ctrl #(
    parameter int W  = 8,
    parameter int H  = 8,
    parameter int K  = 3,
    parameter int AW = 16,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    stride,
    input  logic          out_ready,
    output logic          rd_inram,
    output logic [AW-1:0] pixadr,
    output logic          init0,
    output logic          sh,
    output logic          sel0,
    output logic          avail,
    output logic [CW-1:0] out_row,
    output logic [CW-1:0] out_col,
    output logic          busy,
`ifdef CONV_STALL_CNT_EN
    output logic [15:0]   stall_cnt,
`endif
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_RUN, S_DRAIN, S_DONE
    } state_t;

    localparam logic [AW-1:0] LAST    = AW'(W*H-1);
    localparam logic [CW-1:0] COL_MAX = CW'(W-1);
    localparam logic [CW-1:0] ROW_MAX = CW'(H-1);
    localparam logic [CW-1:0] KM1     = CW'(K-1);
    localparam logic [CW-1:0] ONE     = CW'(1);

    state_t        state_q, state_d;
    logic [1:0]    smax_q, smax_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          pend_q, pend_d;
    logic [CW-1:0] s_row_q, s_row_d;
    logic [CW-1:0] s_col_q, s_col_d;
    // Stride phase and output index of the pixel about to be shifted.
    logic [1:0]    rph_q, rph_d;
    logic [1:0]    cph_q, cph_d;
    logic [CW-1:0] orow_q, orow_d;
    logic [CW-1:0] ocol_q, ocol_d;
    logic          avail_q, avail_d;
    logic [CW-1:0] out_row_q, out_row_d;
    logic [CW-1:0] out_col_q, out_col_d;
    logic          stall;
    logic          fetch;
    logic          hit;
`ifdef CONV_STALL_CNT_EN
    logic [15:0]   scnt_q, scnt_d;
`endif

    always_comb begin
        state_d   = state_q;
        smax_d    = smax_q;
        addr_d    = addr_q;
        pend_d    = pend_q;
        s_row_d   = s_row_q;
        s_col_d   = s_col_q;
        rph_d     = rph_q;
        cph_d     = cph_q;
        orow_d    = orow_q;
        ocol_d    = ocol_q;
        avail_d   = avail_q;
        out_row_d = out_row_q;
        out_col_d = out_col_q;
        rd_inram  = 1'b0;
        init0     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        fetch     = 1'b0;
        stall     = avail_q && !out_ready;
        sh        = pend_q && !stall;
        sel0      = sh && (s_col_q == '0);
        hit       = (s_row_q >= KM1) && (s_col_q >= KM1)
                    && (rph_q == 2'd0) && (cph_q == 2'd0);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    smax_d  = (stride == 2'd0) ? 2'd0 : stride - 2'd1;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                init0   = 1'b1;
                busy    = 1'b1;
                state_d = S_RUN;
            end
            S_RUN: begin
                busy     = 1'b1;
                fetch    = !stall;
                rd_inram = fetch;
                if (fetch) begin
                    if (addr_q == LAST) state_d = S_DRAIN;
                    else                addr_d  = addr_q + AW'(1);
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                // Last pixel shifted and no window left waiting.
                if (!pend_q && (!avail_q || out_ready)) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q == S_INIT) begin
            addr_d    = '0;
            pend_d    = 1'b0;
            s_row_d   = '0;
            s_col_d   = '0;
            rph_d     = 2'd0;
            cph_d     = 2'd0;
            orow_d    = '0;
            ocol_d    = '0;
            avail_d   = 1'b0;
            out_row_d = '0;
            out_col_d = '0;
        end else begin
            if (!stall) begin
                pend_d  = fetch;
                avail_d = sh && hit;
                if (sh && hit) begin
                    out_row_d = orow_q;
                    out_col_d = ocol_q;
                end
            end
            if (sh) begin
                if (s_col_q == COL_MAX) begin
                    s_col_d = '0;
                    cph_d   = 2'd0;
                    ocol_d  = '0;
                    if (s_row_q != ROW_MAX) s_row_d = s_row_q + ONE;
                    if (s_row_q >= KM1) begin
                        if (rph_q == smax_q) begin
                            rph_d  = 2'd0;
                            orow_d = orow_q + ONE;
                        end else begin
                            rph_d = rph_q + 2'd1;
                        end
                    end
                end else begin
                    s_col_d = s_col_q + ONE;
                    if (s_col_q >= KM1) begin
                        if (cph_q == smax_q) begin
                            cph_d  = 2'd0;
                            ocol_d = ocol_q + ONE;
                        end else begin
                            cph_d = cph_q + 2'd1;
                        end
                    end
                end
            end
        end
    end

`ifdef CONV_STALL_CNT_EN
    always_comb begin
        scnt_d = scnt_q;
        if (state_q == S_INIT)                         scnt_d = '0;
        else if (stall && busy && scnt_q != 16'hFFFF) scnt_d = scnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) scnt_q <= '0;
        else      scnt_q <= scnt_d;
    end

    assign stall_cnt = scnt_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            smax_q    <= 2'd0;
            addr_q    <= '0;
            pend_q    <= 1'b0;
            s_row_q   <= '0;
            s_col_q   <= '0;
            rph_q     <= 2'd0;
            cph_q     <= 2'd0;
            orow_q    <= '0;
            ocol_q    <= '0;
            avail_q   <= 1'b0;
            out_row_q <= '0;
            out_col_q <= '0;
        end else begin
            state_q   <= state_d;
            smax_q    <= smax_d;
            addr_q    <= addr_d;
            pend_q    <= pend_d;
            s_row_q   <= s_row_d;
            s_col_q   <= s_col_d;
            rph_q     <= rph_d;
            cph_q     <= cph_d;
            orow_q    <= orow_d;
            ocol_q    <= ocol_d;
            avail_q   <= avail_d;
            out_row_q <= out_row_d;
            out_col_q <= out_col_d;
        end
    end

    assign pixadr  = addr_q;
    assign avail   = avail_q;
    assign out_row = out_row_q;
    assign out_col = out_col_q;

endmodule

// File: tb/tb_conv_stream_ctrl.sv
// tb_conv_stream_ctrl: directed frames on a 5x5 image with a 3x3 kernel.
// Covers the stride, stall, restart-ignore and mid-frame reset scenarios.
module tb_conv_stream_ctrl;

    localparam int N  = 5;
    localparam int K  = 3;
    localparam int AW = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    stride = 2'd1;
    logic          out_ready = 1'b1;
    logic          rd_inram;
    logic [AW-1:0] pixadr;
    logic          init0;
    logic          sh;
    logic          sel0;
    logic          avail;
    logic [CW-1:0] out_row;
    logic [CW-1:0] out_col;
    logic          busy;
    logic          done;
`ifdef CONV_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    int errs = 0;
    int nchk = 0;
    int wc[$];
    int wr[$];
    int wl[$];
    int done_cyc;
    int ndone;
    int nreads;
    int nsh;
    int nsel;

    always #5 clk = ~clk;

    conv_stream_ctrl #(
        .W(N), .H(N), .K(K), .AW(AW), .CW(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .stride(stride),
        .out_ready(out_ready),
        .rd_inram(rd_inram),
        .pixadr(pixadr),
        .init0(init0),
        .sh(sh),
        .sel0(sel0),
        .avail(avail),
        .out_row(out_row),
        .out_col(out_col),
        .busy(busy),
`ifdef CONV_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .done(done)
    );

    task automatic check(input string tag, input int got, input int exp);
        nchk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Runs 60 cycles; cycle c inputs are applied just after a rising edge
    // and outputs are sampled on the following falling edge.
    task automatic run_frame(input logic [1:0] s, input int lo_from,
                             input int lo_to, input int restart,
                             input int rst_from, input int rst_to,
                             input int start_cyc);
        logic [AW-1:0] pa_prev;
        logic [CW-1:0] r_prev;
        logic [CW-1:0] c_prev;
        logic          st_prev;
        wc.delete();
        wr.delete();
        wl.delete();
        done_cyc = -1;
        ndone    = 0;
        nreads   = 0;
        nsh      = 0;
        nsel     = 0;
        st_prev  = 1'b0;
        pa_prev  = '0;
        r_prev   = '0;
        c_prev   = '0;
        for (int c = 0; c < 60; c++) begin
            rst       = !(c >= rst_from && c < rst_to);
            start     = (c == start_cyc) || (c == restart);
            stride    = s;
            out_ready = !(c >= lo_from && c <= lo_to);
            @(negedge clk);
            if (!rst) begin
                check("rst_ctl", {rd_inram, init0, sh, sel0, avail, busy, done}, 0);
                check("rst_adr", pixadr, 0);
                check("rst_rc", {out_row, out_col}, 0);
            end
            if (init0) begin
                nreads = 0;
                nsh    = 0;
                nsel   = 0;
                wc.delete();
                wr.delete();
                wl.delete();
            end
            if (avail && !out_ready) begin
                check("stall_rd", rd_inram, 0);
                check("stall_sh", sh, 0);
                if (st_prev) begin
                    check("stall_adr", pixadr, pa_prev);
                    check("stall_row", out_row, r_prev);
                    check("stall_col", out_col, c_prev);
                end
            end
            if (rd_inram) begin
                check("rd_adr", pixadr, nreads);
                nreads++;
            end
            if (sh) nsh++;
            if (sel0) nsel++;
            if (avail && out_ready) begin
                wc.push_back(c);
                wr.push_back(out_row);
                wl.push_back(out_col);
            end
            if (done) begin
                ndone++;
                done_cyc = c;
            end
            st_prev = avail && !out_ready;
            pa_prev = pixadr;
            r_prev  = out_row;
            c_prev  = out_col;
            @(posedge clk);
            #1;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        rst       = 1'b1;
    endtask

    // Window i of an ow x ow output map ends at pixel
    // (K-1+r*s, K-1+c*s), visible 4 cycles after its fetch-cycle base.
    task automatic verify(input string nm, input int s, input int off,
                          input int exp_done);
        int ow;
        int n;
        int r;
        int c;
        ow = (N - K) / s + 1;
        n  = ow * ow;
        check({nm, "_nwin"}, wc.size(), n);
        for (int i = 0; i < n && i < wc.size(); i++) begin
            r = i / ow;
            c = i % ow;
            check({nm, "_wcyc"}, wc[i], 4 + (K-1+r*s)*N + (K-1+c*s) + off);
            check({nm, "_wrow"}, wr[i], r);
            check({nm, "_wcol"}, wl[i], c);
        end
        check({nm, "_done"}, done_cyc, exp_done);
        check({nm, "_ndone"}, ndone, 1);
        check({nm, "_reads"}, nreads, N*N);
        check({nm, "_shifts"}, nsh, N*N);
        check({nm, "_sel0"}, nsel, N);
    endtask

    initial begin
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ctl", {rd_inram, init0, sh, sel0, avail, busy, done}, 0);
        check("reset_adr", pixadr, 0);
        check("reset_rc", {out_row, out_col}, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run_frame(2'd1, -1, -1, -1, -1, -1, 0);
        verify("s1", 1, 0, 29);
        check("s1_first", wc.size() > 0 ? wc[0] : -1, 16);
        check("s1_last", wc.size() == 9 ? wc[8] : -1, 28);
`ifdef CONV_STALL_CNT_EN
        check("s1_scnt", stall_cnt, 0);
`endif

        run_frame(2'd2, -1, -1, -1, -1, -1, 0);
        verify("s2", 2, 0, 29);
        check("s2_c1", wc.size() > 1 ? wc[1] : -1, 18);
        check("s2_c2", wc.size() > 2 ? wc[2] : -1, 26);

        run_frame(2'd1, 16, 20, -1, -1, -1, 0);
        verify("stall", 1, 5, 34);
`ifdef CONV_STALL_CNT_EN
        check("stall_cnt", stall_cnt, 5);
`endif

        run_frame(2'd1, -1, -1, 10, -1, -1, 0);
        verify("restart", 1, 0, 29);

        run_frame(2'd1, -1, -1, 15, 12, 14, 0);
        verify("rstmid", 1, 15, 44);

        run_frame(2'd0, -1, -1, -1, -1, -1, 0);
        verify("s0", 1, 0, 29);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule

// File: doc/conv_stream_ctrl.md
Name: conv_stream_ctrl

Overview:
- Parametrised successor to the fixed 3x3 convolution control unit.
- Streams a W x H image from the input RAM in raster order and drives shift/zero-select to a KxK line-buffer datapath.
- Flags each valid window (runtime stride 1..3) with its output coordinates.
- Adds a ready/valid output handshake with full pipeline stall, plus busy/done status. Sits between the input RAM and the multiplier array.

Parameters:
W, 8, image width in pixels (>= K)
H, 8, image height in pixels (>= K)
K, 3, kernel size (2..7)
AW, 16, pixel address width (2^AW >= W*H)
CW, 8, coordinate width (2^CW > max(W,H))

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  pulse; begins a frame when idle
stride  in  2  window stride, sampled on accepted start; 0 treated as 1
out_ready  in  1  downstream accepts current window
rd_inram  out  1  read enable to input RAM
pixadr  out  AW  read address
init0  out  1  clear datapath line buffer
sh  out  1  shift the RAM output pixel into the line buffer
sel0  out  1  with sh: shifted pixel is first of its row (col 0)
avail  out  1  window valid
out_row  out  CW  output-map row of current window
out_col  out  CW  output-map column of current window
busy  out  1  frame in progress
done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (rst=0, async): FSM=IDLE; all outputs 0; all counters and valid flags 0. Reset mid-frame aborts the frame and gives no done.
- The input RAM holds its data output while rd_inram=0, with read latency 1.
- FSM states:
  - IDLE: start=1 -> INIT, latching the stride.
  - INIT (1 cycle): init0=1, busy=1, counters cleared -> RUN.
  - RUN: issues reads; -> DRAIN when the read of address W*H-1 is issued.
  - DRAIN: no reads; waits for the last pixel to be shifted and avail to be accepted or dropped -> DONE.
  - DONE (1 cycle): done=1, busy=0 -> IDLE.
- busy=1 in INIT, RUN and DRAIN. start is ignored while not IDLE.
- Three-stage pipeline:
  - Fetch: rd_inram=1 with pixadr=p (0..W*H-1, +1 per issued read).
  - Shift: the first non-stalled cycle after fetch p asserts sh for pixel p, with tracked (s_row, s_col); sel0 = sh && s_col==0.
  - Window: avail is registered and set the cycle after a shift of (r,c) where r>=K-1, c>=K-1, (r-K+1)%S==0 and (c-K+1)%S==0. out_row=(r-K+1)/S and out_col=(c-K+1)/S are registered with it. Use increment/wrap counters, no dividers.
- Handshake:
  - stall = avail && !out_ready.
  - On stall: rd_inram=0, sh=0; pixadr, the pipeline, avail, out_row and out_col all hold.
  - A window is consumed on avail && out_ready; avail drops next cycle unless a new window is produced.
- Column counter wraps W-1 -> 0 and increments row; the row counter stops at H-1.
- Window count per frame = ((H-K)/S+1)*((W-K)/S+1). Pixels not covered by stride are shifted but never flagged.
- Zero-stall timing (start high in cycle 0):
  - INIT in cycle 1.
  - Fetch of p in cycle 2+p; sh in cycle 3+p.
  - avail for window ending at (r,c) in cycle 4+r*W+c.
  - done in the cycle after the last window is consumed.

Optional Feature:
- Macro: CONV_STALL_CNT_EN.
- Defined:
  - Extra output stall_cnt[15:0] counts cycles with stall=1 during the frame, saturating at 16'hFFFF.
  - Cleared in INIT and by reset; holds its value after done.
- Undefined: no port and no counter logic.

Test Plan:
- W=H=5, K=3, stride=1, out_ready=1, start in cycle 0:
  - 9 windows, first avail cycle 16 with (0,0), last cycle 28 with (2,2).
  - done in cycle 29; 25 reads, addresses 0..24.
- Same setup, stride=2: 4 windows, (0,0),(0,1),(1,0),(1,1), at cycles 16, 18, 26, 28; done in cycle 29.
- stride=1, out_ready=0 for 5 cycles on the first avail:
  - rd_inram=0, sh=0, pixadr and out_row/out_col held during the stall.
  - Resumes with no lost or duplicated pixel; done in cycle 34.
- start re-pulsed in cycle 10 mid-frame: ignored, and the window sequence is identical to the first test.
- rst asserted in cycle 12, released in cycle 14, start in cycle 15:
  - Outputs are 0 during reset and there is no done pulse.
  - The new frame matches the first test shifted by 15 cycles.
- CONV_STALL_CNT_EN defined, with the third test's stall: stall_cnt=5 after done.
